tach_counter: RTL and testbench
===============================

# tach_counter

Tachometer front end for the wall-follower motor loop. It samples the asynchronous tach/encoder pulse line, synchronizes and glitch-filters it, and counts rising edges over a fixed sample window. Once per window it publishes the unsigned count as the `feedback` process variable for `pid_controller`. The one-cycle window strobe drives the PID's `clk_en`, so the controller runs exactly once per fresh measurement.

## Interface
- `TACH_COUNT_RESOLUTION`, default 8: width of the published count (W).
- `WINDOW_CYCLES`, default 125000: sample window length in clk cycles (1 ms at 125 MHz); must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flop depth; must be ≥ 2.
- `GLITCH_CYCLES`, default 4: consecutive cycles a new input level must hold before it is accepted; must be ≥ 1.

Ports:
- `clk` in 1: system clock, 125 MHz.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: measurement enable.
- `tach_in` in 1: raw tach pulse, asynchronous to clk.
- `count` out W: unsigned edges counted in the last completed window. Feeds PID `feedback`.
- `count_valid` out 1: one-cycle strobe when `count` updates. Feeds PID `clk_en`.
- `overflow` out 1: the last completed window saturated.

## Operation
- Synchronizer: a SYNC_STAGES flop chain on `tach_in`, all flops reset to 0. The last stage is `s`.
- Glitch filter: a filtered level `f` (reset 0) and a stability counter (reset 0).
  - If `s != f`, the counter increments.
  - When `s != f` and the counter equals GLITCH_CYCLES-1, `f <= s` and the counter clears.
  - If `s == f`, the counter clears.
  - A pulse shorter than GLITCH_CYCLES cycles never reaches `f`.
- Edge detect: a rising edge of `f` (`f` high, previous `f` low) produces an increment request.
- Running counter: W bits, reset 0.
  - Each increment request adds 1, saturating at 2^W-1.
  - A request arriving while the counter is already 2^W-1 sets the window-sticky flag `ovf_w`.
- Window counter: range 0..WINDOW_CYCLES-1, reset 0.
  - While `en`=1 it increments each cycle.
  - On the terminal value it wraps to 0 and closes the window.
- Window close, all in the same edge:
  - `count <=` running counter, including any increment request present in that same cycle.
  - `overflow <=` `ovf_w`, including a saturating request in that same cycle.
  - `count_valid <= 1`.
  - The running counter and `ovf_w` clear to 0.
- `en`=0:
  - The window counter, running counter and `ovf_w` are held at 0.
  - `count_valid`=0.
  - `count` and `overflow` hold their last values.
  - Synchronizer and filter keep running, so a level change in progress is not lost.
- Simultaneous events: an edge request in the closing cycle belongs to the closing window. The new window starts at 0.

## Timing
- Reset values: `count`=0, `count_valid`=0, `overflow`=0. All internal state is 0.
- Reset mid-window:
  - Takes effect immediately (asynchronous); no strobe is issued.
  - After release, the first window starts at the first edge with `en` sampled high.
- Edge latency (tach_in changes just after clk edge k):
  - `s` changes after edge k+SYNC_STAGES.
  - `f` changes after edge k+SYNC_STAGES+GLITCH_CYCLES.
  - The running counter changes after the following edge.
- Strobe timing:
  - `count_valid` goes high after the WINDOW_CYCLES-th consecutive edge at which `en` is sampled high.
  - It is exactly one cycle wide.
  - Period is exactly WINDOW_CYCLES while `en` stays high.
- Dropping `en` mid-window discards the partial window. Re-asserting `en` starts a full window.
- `count` is stable between strobes. The PID samples it on the strobe cycle.

## Test plan
Use a synchronous bench drive of `tach_in`, WINDOW_CYCLES=100, GLITCH_CYCLES=4, SYNC_STAGES=2, W=8 unless stated.
1. Reset with `en`=1 and `tach_in` toggling.
   -> `count`=0, `count_valid`=0, `overflow`=0 throughout reset.
   -> First strobe arrives 100 cycles after the first edge sampling `en` high after reset release.
2. Clean square wave, 10 cycles high / 10 cycles low.
   -> Every strobe reports `count`=5 after the first full window, with `overflow`=0.
   -> Strobes occur every 100 cycles.
3. Pulse width filtering.
   -> Ten 3-cycle-high pulses spaced 10 cycles apart in one window give `count`=0.
   -> The same pattern with 4-cycle-high pulses gives `count`=10.
4. Saturation with WINDOW_CYCLES=5000 and a 5 high / 5 low wave (500 edges).
   -> `count`=255, `overflow`=1.
   -> The next window at a 25 high / 25 low wave (100 edges) reports `count`=100, `overflow`=0.
5. Deassert `en` for 30 cycles at window cycle 60.
   -> No strobe during or for that window; `count` holds its prior value.
   -> The next strobe is exactly 100 cycles after `en` re-assertion.
6. Edge exactly on a window boundary (the increment request lands in the terminal cycle).
   -> It is counted in the closing window.
   -> The following window does not include it.

Source files
------------

// File: rtl/tach_counter.sv
// tach_counter
// Tachometer front end for the motor loop. It synchronizes the asynchronous
// tach pulse, glitch-filters it and counts its rising edges over a fixed
// window. Once per window it publishes the count together with a one-cycle
// strobe, which serves as the PID's clock enable.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           measurement enable; low discards the partial window
//   tach_in      raw tach pulse, asynchronous to clk
//   count        edges counted in the last completed window (saturating)
//   count_valid  one-cycle strobe, high in the cycle that count updates
//   overflow     the last completed window saturated
module tach_counter #(
  parameter int TACH_COUNT_RESOLUTION = 8,
  parameter int WINDOW_CYCLES         = 125000,
  parameter int SYNC_STAGES           = 2,
  parameter int GLITCH_CYCLES         = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             tach_in,
  output logic [TACH_COUNT_RESOLUTION-1:0] count,
  output logic                             count_valid,
  output logic                             overflow
);

  localparam int W     = TACH_COUNT_RESOLUTION;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int GC_W  = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(GLITCH_CYCLES - 1);
  localparam logic [W-1:0]     CNT_MAX  = '1;

  // Synchronizer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], tach_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Glitch filter: a new level of s must differ from f for GLITCH_CYCLES
  // consecutive cycles before f follows it. Any return to f restarts the
  // count, so short pulses never propagate.
  logic            f_q;
  logic            f_prev_q;
  logic [GC_W-1:0] gcnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q      <= 1'b0;
      f_prev_q <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      f_prev_q <= f_q;
      if (s != f_q) begin
        if (gcnt_q == GC_LAST) begin
          f_q    <= s;
          gcnt_q <= '0;
        end else begin
          gcnt_q <= gcnt_q + 1'b1;
        end
      end else begin
        gcnt_q <= '0;
      end
    end
  end

  // Increment request: one cycle per filtered rising edge
  logic inc;
  assign inc = f_q & ~f_prev_q;

  // Window / running count
  logic [WIN_W-1:0] win_q;
  logic [W-1:0]     run_q;
  logic             ovf_w_q;
  logic [W-1:0]     run_next;
  logic             ovf_next;
  logic             at_max;
  logic             win_last;

  assign at_max   = (run_q == CNT_MAX);
  assign win_last = (win_q == WIN_LAST);

  // run_next/ovf_next fold in this cycle's request, so an edge landing in
  // the closing cycle is published with the closing window.
  always_comb begin
    run_next = run_q;
    ovf_next = ovf_w_q;
    if (inc) begin
      if (at_max) ovf_next = 1'b1;
      else        run_next = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q       <= '0;
      run_q       <= '0;
      ovf_w_q     <= 1'b0;
      count       <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else if (!en) begin
      // Partial window discarded; published values hold.
      win_q       <= '0;
      run_q       <= '0;
      ovf_w_q     <= 1'b0;
      count_valid <= 1'b0;
    end else if (win_last) begin
      win_q       <= '0;
      count       <= run_next;
      overflow    <= ovf_next;
      count_valid <= 1'b1;
      run_q       <= '0;
      ovf_w_q     <= 1'b0;
    end else begin
      win_q       <= win_q + 1'b1;
      run_q       <= run_next;
      ovf_w_q     <= ovf_next;
      count_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tach_counter.sv
// Bench for tach_counter. Two instances share clk and tach_in: dut_a uses a
// 100-cycle window, and dut_b uses a 5000-cycle window for the saturation
// case. The reference model works from the sequence of sampled tach levels.
// A level is accepted once it has been seen for G consecutive samples after
// the sync delay, and an accepted rise is credited one edge later to any
// window that is open at that edge.
module tb_tach_counter;
  localparam int S    = 2;
  localparam int G    = 4;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic       tach_in = 1'b0;
  logic [7:0] count_a, count_b;
  logic       count_valid_a, count_valid_b, overflow_a, overflow_b;

  always #4 clk = ~clk;

  tach_counter #(.TACH_COUNT_RESOLUTION(8), .WINDOW_CYCLES(100),
                 .SYNC_STAGES(S), .GLITCH_CYCLES(G)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .tach_in(tach_in),
    .count(count_a), .count_valid(count_valid_a), .overflow(overflow_a));

  tach_counter #(.TACH_COUNT_RESOLUTION(8), .WINDOW_CYCLES(5000),
                 .SYNC_STAGES(S), .GLITCH_CYCLES(G)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .tach_in(tach_in),
    .count(count_b), .count_valid(count_valid_b), .overflow(overflow_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model
  bit samp[$];
  int ne;
  bit acc, pend;
  int wlen[2] = '{100, 5000};
  int epos[2], sum[2], e_cnt[2];
  bit e_ovf[2], e_vld[2];
  int cyc;
  bit vld_a_seen, vld_b_seen;

  // Filter input seen at edge e: sample taken S edges earlier, 0 before reset release
  function automatic bit fi(input int e);
    return (e - S >= 1) ? samp[e-S-1] : 1'b0;
  endfunction

  task automatic model_reset();
    samp.delete();
    ne = 0; acc = 0; pend = 0;
    for (int d = 0; d < 2; d++) begin
      epos[d] = 0; sum[d] = 0; e_cnt[d] = 0; e_ovf[d] = 0; e_vld[d] = 0;
    end
  endtask

  task automatic model_edge(input bit t, input bit ea, input bit eb);
    bit inc, en, all_new;
    inc = pend;
    samp.push_back(t);
    ne++;
    for (int d = 0; d < 2; d++) begin
      en = (d == 0) ? ea : eb;
      e_vld[d] = 0;
      if (!en) begin
        epos[d] = 0; sum[d] = 0;
      end else begin
        epos[d]++;
        sum[d] += int'(inc);
        if (epos[d] == wlen[d]) begin
          e_cnt[d] = (sum[d] > CMAX) ? CMAX : sum[d];
          e_ovf[d] = (sum[d] > CMAX);
          e_vld[d] = 1;
          epos[d] = 0; sum[d] = 0;
        end
      end
    end
    all_new = 1;
    for (int k = 0; k < G; k++) if (fi(ne - k) == acc) all_new = 0;
    pend = 0;
    if (all_new) begin
      acc  = ~acc;
      pend = acc;
    end
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge
  task automatic step(input bit t);
    tach_in = t;
    @(posedge clk);
    if (!reset) model_edge(t, en_a, en_b);
    @(negedge clk);
    cyc++;
    chk("vld_a", 32'(count_valid_a), 32'(e_vld[0]));
    chk("cnt_a", 32'(count_a), e_cnt[0]);
    chk("ovf_a", 32'(overflow_a), 32'(e_ovf[0]));
    chk("vld_b", 32'(count_valid_b), 32'(e_vld[1]));
    chk("cnt_b", 32'(count_b), e_cnt[1]);
    chk("ovf_b", 32'(overflow_b), 32'(e_ovf[1]));
    vld_a_seen = count_valid_a;
    vld_b_seen = count_valid_b;
  endtask

  initial begin
    int n, ns, last, rem;
    bit lvl;
    model_reset();
    cyc = 0;

    // 1: reset held with en high and tach toggling
    @(negedge clk);
    en_a = 1'b1;
    for (int i = 0; i < 8; i++) step(i[0]);
    reset = 1'b0;
    n = 0;
    do begin step(1'b0); n++; end while (!vld_a_seen && n < 300);
    chk("first_strobe_lat", n, 100);

    // 2: 10/10 square wave, 5 edges per window, period 100
    ns = 0; last = cyc;
    for (int i = 0; i < 500; i++) begin
      step((i % 20) < 10);
      if (vld_a_seen) begin
        ns++;
        chk("sq_cnt", 32'(count_a), 5);
        chk("sq_ovf", 32'(overflow_a), 0);
        chk("sq_period", cyc - last, 100);
        last = cyc;
      end
    end
    chk("sq_strobes", ns, 5);

    // 3: pulse width filtering, window-aligned
    for (int i = 0; i < 100; i++) step((i % 10) < 3);
    chk("p3_vld", 32'(vld_a_seen), 1);
    chk("p3_cnt", 32'(count_a), 0);
    for (int i = 0; i < 100; i++) step((i % 10) < 4);
    chk("p4_vld", 32'(vld_a_seen), 1);
    chk("p4_cnt", 32'(count_a), 10);

    // 4: saturation on the long-window instance
    en_b = 1'b1;
    for (int i = 0; i < 5000; i++) step((i % 10) < 5);
    chk("sat_vld", 32'(vld_b_seen), 1);
    chk("sat_cnt", 32'(count_b), 255);
    chk("sat_ovf", 32'(overflow_b), 1);
    for (int i = 0; i < 5000; i++) step((i % 50) < 25);
    chk("unsat_vld", 32'(vld_b_seen), 1);
    chk("unsat_cnt", 32'(count_b), 100);
    chk("unsat_ovf", 32'(overflow_b), 0);
    en_b = 1'b0;

    // 5: en dropped at window cycle 60 for 30 cycles
    ns = 0;
    for (int i = 0; i < 60; i++) begin
      step((i % 20) < 10);
      if (vld_a_seen) ns++;
    end
    en_a = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step((i % 20) < 10);
      if (vld_a_seen) ns++;
    end
    chk("off_nostrobe", ns, 0);
    chk("off_hold", 32'(count_a), e_cnt[0]);
    en_a = 1'b1;
    n = 0;
    do begin step(1'b0); n++; end while (!vld_a_seen && n < 300);
    chk("reen_lat", n, 100);

    // 6: request landing in the closing cycle
    for (int i = 1; i <= 200; i++) begin
      step(i >= 94);
      if (i == 100) begin
        chk("bnd_vld", 32'(vld_a_seen), 1);
        chk("bnd_in", 32'(count_a), 1);
      end
      if (i == 200) begin
        chk("bnd_next_vld", 32'(vld_a_seen), 1);
        chk("bnd_next", 32'(count_a), 0);
      end
    end

    // Random pulse train with occasional en toggles and an async reset
    lvl = 1'b1; rem = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1'b1;
        #1;
        chk("arst_cnt_a", 32'(count_a), 0);
        chk("arst_vld_a", 32'(count_valid_a), 0);
        chk("arst_ovf_a", 32'(overflow_a), 0);
        chk("arst_cnt_b", 32'(count_b), 0);
        model_reset();
        for (int k = 0; k < 3; k++) step(k[0]);
        reset = 1'b0;
      end
      if (rem == 0) begin
        lvl = ~lvl;
        rem = int'($urandom_range(1, 12));
      end
      rem--;
      if ($urandom_range(0, 199) == 0) en_a = ~en_a;
      step(lvl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
